gf256_mixcol_seq: RTL and testbench

Sequential AES MixColumns / InvMixColumns engine for one 32-bit state column. It time-shares NMUL generic GF(2^8) multipliers (reduction polynomial 0x11B) across the 16 matrix-by-column products. A controller FSM sequences these products into an XOR accumulator. Sits between the round-key/state datapath and the AES round controller, behind a valid/ready handshake on each side.

---
 rtl/gf256_mixcol_seq.sv | 145 ++++++++++++++
 tb/tb_gf256_mixcol_seq.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gf256_mixcol_seq.sv
// Sequential AES MixColumns / InvMixColumns engine for one 32-bit column.
// NMUL GF(2^8) multipliers are time-shared over the 16 matrix-by-column products.
module gf256_mixcol_seq #(
    parameter int unsigned NMUL = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_col,
    input  logic        in_inv,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_col,
    output logic        busy
);

    localparam int unsigned NSTEPS    = 16 / NMUL;
    localparam logic [3:0]  LAST_STEP = 4'(NSTEPS - 1);

    generate
        if (NMUL != 1 && NMUL != 2 && NMUL != 4) begin : g_bad_nmul
            $error("gf256_mixcol_seq: NMUL must be 1, 2 or 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [3:0][7:0] col_q, col_d;
    logic            inv_q, inv_d;
    logic [3:0][7:0] acc_q, acc_d, acc_nx;
    logic [3:0]      step_q, step_d;
    logic [31:0]     out_col_q, out_col_d;

    // Shift-and-add product modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gfmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] prod;
        logic [7:0] sh;
        prod = '0;
        sh   = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) begin
                prod = prod ^ sh;
            end
            sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1B : 8'h00);
        end
        return prod;
    endfunction

    function automatic logic [7:0] base_coef(input logic inv, input logic [1:0] k);
        logic [7:0] coef;
        case (k)
            2'd0:    coef = inv ? 8'h0E : 8'h02;
            2'd1:    coef = inv ? 8'h0B : 8'h03;
            2'd2:    coef = inv ? 8'h0D : 8'h01;
            default: coef = inv ? 8'h09 : 8'h01;
        endcase
        return coef;
    endfunction

    // Products p = step*NMUL + j fold into row p/4 using byte p%4 of the column.
    always_comb begin : products
        logic [3:0] p;
        logic [1:0] r;
        logic [1:0] c;
        logic [1:0] k;
        p      = '0;
        r      = '0;
        c      = '0;
        k      = '0;
        acc_nx = acc_q;
        for (int unsigned j = 0; j < NMUL; j++) begin
            p         = 4'(32'(step_q) * NMUL + j);
            r         = p[3:2];
            c         = p[1:0];
            k         = c - r;
            acc_nx[r] = acc_nx[r] ^ gfmul(base_coef(inv_q, k), col_q[c]);
        end
    end

    always_comb begin : fsm
        state_d   = state_q;
        col_d     = col_q;
        inv_d     = inv_q;
        acc_d     = acc_q;
        step_d    = step_q;
        out_col_d = out_col_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    col_d   = in_col;
                    inv_d   = in_inv;
                    acc_d   = '0;
                    step_d  = '0;
                    state_d = MUL;
                end
            end
            MUL: begin
                acc_d  = acc_nx;
                step_d = step_q + 4'd1;
                if (step_q == LAST_STEP) begin
                    out_col_d = acc_nx;
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            col_q     <= '0;
            inv_q     <= 1'b0;
            acc_q     <= '0;
            step_q    <= '0;
            out_col_q <= '0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            inv_q     <= inv_d;
            acc_q     <= acc_d;
            step_q    <= step_d;
            out_col_q <= out_col_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_col   = out_col_q;

endmodule

// File: tb/tb_gf256_mixcol_seq.sv
// Directed bench for gf256_mixcol_seq, run against NMUL = 1, 2 and 4 instances.
module tb_gf256_mixcol_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid_a  [3];
    logic        in_ready_a  [3];
    logic [31:0] in_col_a    [3];
    logic        in_inv_a    [3];
    logic        out_valid_a [3];
    logic        out_ready_a [3];
    logic [31:0] out_col_a   [3];
    logic        busy_a      [3];

    int cyc      = 0;
    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        gf256_mixcol_seq #(.NMUL(1 << g)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid_a[g]),
            .in_ready  (in_ready_a[g]),
            .in_col    (in_col_a[g]),
            .in_inv    (in_inv_a[g]),
            .out_valid (out_valid_a[g]),
            .out_ready (out_ready_a[g]),
            .out_col   (out_col_a[g]),
            .busy      (busy_a[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    // Reference model written from the textbook MixColumns equations.
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
    endfunction
    function automatic logic [7:0] m3(input logic [7:0] a);
        return xt(a) ^ a;
    endfunction
    function automatic logic [7:0] m9(input logic [7:0] a);
        return xt(xt(xt(a))) ^ a;
    endfunction
    function automatic logic [7:0] mb(input logic [7:0] a);
        return xt(xt(xt(a))) ^ xt(a) ^ a;
    endfunction
    function automatic logic [7:0] md(input logic [7:0] a);
        return xt(xt(xt(a))) ^ xt(xt(a)) ^ a;
    endfunction
    function automatic logic [7:0] me(input logic [7:0] a);
        return xt(xt(xt(a))) ^ xt(xt(a)) ^ xt(a);
    endfunction

    function automatic logic [31:0] mix_fwd(input logic [31:0] col);
        logic [7:0] s0, s1, s2, s3;
        s0 = col[7:0]; s1 = col[15:8]; s2 = col[23:16]; s3 = col[31:24];
        return {m3(s0) ^ s1 ^ s2 ^ xt(s3),
                s0 ^ s1 ^ xt(s2) ^ m3(s3),
                s0 ^ xt(s1) ^ m3(s2) ^ s3,
                xt(s0) ^ m3(s1) ^ s2 ^ s3};
    endfunction

    function automatic logic [31:0] mix_inv(input logic [31:0] col);
        logic [7:0] s0, s1, s2, s3;
        s0 = col[7:0]; s1 = col[15:8]; s2 = col[23:16]; s3 = col[31:24];
        return {mb(s0) ^ md(s1) ^ m9(s2) ^ me(s3),
                md(s0) ^ m9(s1) ^ me(s2) ^ mb(s3),
                m9(s0) ^ me(s1) ^ mb(s2) ^ md(s3),
                me(s0) ^ mb(s1) ^ md(s2) ^ m9(s3)};
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input int k, input logic [31:0] col, input logic inv, output int acc_cyc);
        int t = 0;
        in_col_a[k]   = col;
        in_inv_a[k]   = inv;
        in_valid_a[k] = 1'b1;
        while (!in_ready_a[k] && t < 200) begin
            @(negedge clk);
            t++;
        end
        check($sformatf("n%0d accept_in_time", 1 << k), 32'(t < 200), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid_a[k] = 1'b0;
        acc_cyc = cyc;
    endtask

    task automatic collect(input int k, output logic [31:0] res, output int rise_cyc);
        int t = 0;
        while (!out_valid_a[k] && t < 200) begin
            @(negedge clk);
            t++;
        end
        check($sformatf("n%0d result_in_time", 1 << k), 32'(t < 200), 32'd1);
        res      = out_col_a[k];
        rise_cyc = cyc;
    endtask

    task automatic run_col(input int k, input logic [31:0] col, input logic inv,
                           input logic [31:0] exp, input string tag);
        int          a, rise;
        logic [31:0] res;
        send(k, col, inv, a);
        collect(k, res, rise);
        check($sformatf("n%0d %s out_col", 1 << k, tag), res, exp);
        check($sformatf("n%0d %s latency", 1 << k, tag), 32'(rise - a), 32'(16 >> k));
        @(negedge clk);
        check($sformatf("n%0d %s in_ready_after", 1 << k, tag), 32'(in_ready_a[k]), 32'd1);
        check($sformatf("n%0d %s out_valid_after", 1 << k, tag), 32'(out_valid_a[k]), 32'd0);
    endtask

    task automatic test_backpressure(input int k);
        int          a, rise;
        logic [31:0] res;
        out_ready_a[k] = 1'b0;
        send(k, 32'h455313DB, 1'b0, a);
        collect(k, res, rise);
        check($sformatf("n%0d bp first", 1 << k), res, 32'hBCA14D8E);
        in_col_a[k]   = 32'h5C220AF2;
        in_inv_a[k]   = 1'b0;
        in_valid_a[k] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("n%0d bp out_valid c%0d", 1 << k, i), 32'(out_valid_a[k]), 32'd1);
            check($sformatf("n%0d bp out_col c%0d", 1 << k, i), out_col_a[k], 32'hBCA14D8E);
            check($sformatf("n%0d bp in_ready c%0d", 1 << k, i), 32'(in_ready_a[k]), 32'd0);
        end
        out_ready_a[k] = 1'b1;
        @(negedge clk);
        check($sformatf("n%0d bp released out_valid", 1 << k), 32'(out_valid_a[k]), 32'd0);
        check($sformatf("n%0d bp released in_ready", 1 << k), 32'(in_ready_a[k]), 32'd1);
        check($sformatf("n%0d bp released out_col", 1 << k), out_col_a[k], 32'hBCA14D8E);
        send(k, 32'h5C220AF2, 1'b0, a);
        collect(k, res, rise);
        check($sformatf("n%0d bp second", 1 << k), res, 32'h9D58DC9F);
        check($sformatf("n%0d bp second latency", 1 << k), 32'(rise - a), 32'(16 >> k));
        @(negedge clk);
    endtask

    task automatic test_reset(input int k);
        int   a;
        int   s;
        logic stale = 1'b0;
        s = ((16 >> k) - 1 < 7) ? (16 >> k) - 1 : 7;
        send(k, 32'hBCA14D8E, 1'b1, a);
        repeat (s) @(negedge clk);
        check($sformatf("n%0d rst busy_before", 1 << k), 32'(busy_a[k]), 32'd1);
        #2 rst = 1'b1;
        #1;
        check($sformatf("n%0d rst out_valid", 1 << k), 32'(out_valid_a[k]), 32'd0);
        check($sformatf("n%0d rst in_ready", 1 << k), 32'(in_ready_a[k]), 32'd1);
        check($sformatf("n%0d rst busy", 1 << k), 32'(busy_a[k]), 32'd0);
        check($sformatf("n%0d rst out_col", 1 << k), out_col_a[k], 32'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid_a[k]) stale = 1'b1;
        end
        check($sformatf("n%0d rst no_stale", 1 << k), 32'(stale), 32'd0);
        run_col(k, 32'h455313DB, 1'b0, 32'hBCA14D8E, "post_rst");
    endtask

    task automatic test_b2b(input int k);
        logic [31:0] cols [4];
        logic [31:0] got  [4];
        int          rise [4];
        cols[0] = 32'h455313DB;
        cols[1] = 32'h5C220AF2;
        cols[2] = 32'hC6C6C6C6;
        cols[3] = 32'h01010101;
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    int t = 0;
                    in_col_a[k]   = cols[i];
                    in_inv_a[k]   = 1'b0;
                    in_valid_a[k] = 1'b1;
                    while (!in_ready_a[k] && t < 200) begin
                        @(negedge clk);
                        t++;
                    end
                    @(posedge clk);
                    @(negedge clk);
                end
                in_valid_a[k] = 1'b0;
            end
            begin
                for (int i = 0; i < 4; i++) begin
                    int t = 0;
                    while (!out_valid_a[k] && t < 200) begin
                        @(negedge clk);
                        t++;
                    end
                    check($sformatf("n%0d b2b in_time r%0d", 1 << k, i), 32'(t < 200), 32'd1);
                    got[i]  = out_col_a[k];
                    rise[i] = cyc;
                    @(negedge clk);
                end
            end
        join
        check($sformatf("n%0d b2b r0", 1 << k), got[0], 32'hBCA14D8E);
        check($sformatf("n%0d b2b r1", 1 << k), got[1], 32'h9D58DC9F);
        check($sformatf("n%0d b2b r2", 1 << k), got[2], 32'hC6C6C6C6);
        check($sformatf("n%0d b2b r3", 1 << k), got[3], 32'h01010101);
        for (int i = 1; i < 4; i++) begin
            check($sformatf("n%0d b2b spacing r%0d", 1 << k, i),
                  32'(rise[i] - rise[i-1]), 32'((16 >> k) + 2));
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_valid_a[k]  = 1'b0;
            in_col_a[k]    = '0;
            in_inv_a[k]    = 1'b0;
            out_ready_a[k] = 1'b1;
        end
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("n%0d reset in_ready", 1 << k), 32'(in_ready_a[k]), 32'd1);
            check($sformatf("n%0d reset out_valid", 1 << k), 32'(out_valid_a[k]), 32'd0);
            check($sformatf("n%0d reset busy", 1 << k), 32'(busy_a[k]), 32'd0);
            check($sformatf("n%0d reset out_col", 1 << k), out_col_a[k], 32'h0);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int k = 0; k < 3; k++) begin
            run_col(k, 32'h455313DB, 1'b0, 32'hBCA14D8E, "fwd_db13");
            run_col(k, 32'h5C220AF2, 1'b0, 32'h9D58DC9F, "fwd_f20a");
            run_col(k, 32'hC6C6C6C6, 1'b0, 32'hC6C6C6C6, "fwd_c6");
            run_col(k, 32'h01010101, 1'b0, 32'h01010101, "fwd_01");
            run_col(k, 32'hBCA14D8E, 1'b1, 32'h455313DB, "inv_8e4d");
            run_col(k, 32'h9D58DC9F, 1'b1, 32'h5C220AF2, "inv_9fdc");
            for (int i = 0; i < 256; i++) begin
                logic [31:0] col;
                logic [31:0] fwd;
                col = $urandom;
                fwd = mix_fwd(col);
                check($sformatf("n%0d model_inv_of_fwd %0d", 1 << k, i), mix_inv(fwd), col);
                run_col(k, col, 1'b0, fwd, "rt_fwd");
                run_col(k, fwd, 1'b1, col, "rt_inv");
            end
            test_backpressure(k);
            test_reset(k);
            test_b2b(k);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
